seg_display_scheduler: RTL and testbench
========================================

Name: seg_display_scheduler

Overview:
- Time-multiplexes N_CH two-digit decimal channels onto the DE4's pair of 7-segment digits.
- Each enabled channel is shown in turn for a fixed dwell time, with an optional blank gap between channels.
- Supports hold and manual stepping.
- Any requester can pre-empt the rotation with a timed two-digit hex alert.
- Sits between the control/measurement logic and the SEG0/SEG1 board pins.

Parameters:
- N_CH, 4, number of display channels (2..16).
- DWELL_CYCLES, 50_000_000, clock cycles each channel is shown (≥1).
- GAP_CYCLES, 5_000_000, blank cycles between channels; 0 disables the gap.
- ALERT_CYCLES, 100_000_000, clock cycles an alert is shown (≥1).

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_value  in  8*N_CH  channel k value at [8k+7:8k], decimal 0..99.
- i_dp  in  2*N_CH  channel k decimal points at [2k+1:2k], low digit first, passed through (0 = on).
- i_en  in  N_CH  channel enable mask.
- i_hold  in  1  level; freezes the dwell timer in SHOW.
- i_next  in  1  single-cycle pulse; advance to the next channel.
- i_alert_req  in  1  single-cycle pulse; start or retrigger an alert.
- i_alert_hex  in  8  alert digits in hex, sampled with i_alert_req.
- o_SEG  out  16  {dp1,g..a tens, dp0,g..a units}, active-low.
- o_ch  out  $clog2(N_CH)  channel currently selected.
- o_alert  out  1  high while an alert is displayed.

Behaviour:
- Reset (asynchronous, active-high) forces: o_SEG=16'hFFFF, o_ch=0, o_alert=0, state=SHOW, timer=0, latched alert=0.
- All outputs are registered. A change on i_value or i_dp appears on o_SEG one cycle later.
- SHOW:
  - o_SEG is the encoding of i_value/i_dp for channel o_ch.
  - Values >99 display dash-dash (16'hBFBF, dp forced off).
  - The timer counts up unless i_hold=1. At timer=DWELL_CYCLES-1 the block moves to GAP (or, if GAP_CYCLES=0, straight to the next enabled channel in SHOW). The result is exactly DWELL_CYCLES display cycles per channel.
  - i_next=1 moves to GAP/next immediately, regardless of i_hold.
- GAP:
  - o_SEG=16'hFFFF for GAP_CYCLES cycles.
  - Then SHOW on the next enabled channel with timer=0.
  - i_next is ignored.
- Next channel selection:
  - Round-robin search from o_ch+1, wrapping N_CH-1→0; the first channel with i_en set wins.
  - If o_ch is the only enabled channel, o_ch is unchanged.
  - If i_en=0 (all disabled): stay in SHOW, show 16'hBFBF, o_ch unchanged, timer held at 0.
  - If the current channel becomes disabled in SHOW: advance on the next cycle, as if i_next=1.
- ALERT:
  - Entered from any state on i_alert_req.
  - Latches i_alert_hex. o_SEG shows the hex digits, low digit at [6:0], both dp off. o_alert=1.
  - Lasts ALERT_CYCLES cycles, then returns to SHOW on the same o_ch with timer=0. An interrupted GAP is abandoned.
  - i_alert_req during ALERT re-latches the hex value and restarts the alert timer.
  - i_next and i_hold are ignored during ALERT.
- Simultaneous events:
  - i_alert_req beats i_next and the dwell expiry; the pending advance is dropped.
  - i_next coinciding with the dwell expiry is a single advance, not two.
- Timer width: $clog2(max(DWELL_CYCLES, GAP_CYCLES, ALERT_CYCLES)+1). One shared timer serves all states and is cleared on every state entry.
- Reset asserted mid-operation returns the block to the reset values immediately, regardless of state.

Decomposition:
- Shared package display_pkg holds:
  - SEG_BLANK=7'h7F, SEG_DASH=7'b0111111.
  - OFF_PAIR=16'hFFFF, DASH_PAIR=16'hBFBF.
  - State enum {SHOW, GAP, ALERT}.
- Digit encoding reuses the team's existing num2seg (decimal) and hex2seg_couple (alert) converters.
- One new combinational sub-module, seg_next_ch: inputs current index and i_en; outputs the next enabled index and an any_en flag.

Test Plan (N_CH=4, DWELL=8, GAP=2, ALERT=5):
- Reset release, i_en=4'b1111, ch0=42, dp=2'b11 → o_SEG=16'h99A4 for 8 cycles, 16'hFFFF for 2 cycles, then ch1; after ch3 the display wraps to ch0.
- i_en=4'b0101 → o_ch sequence 0,2,0,2. Then i_en=0 → o_SEG=16'hBFBF and o_ch frozen. Separately, ch value 123 → 16'hBFBF.
- i_hold=1 for 20 cycles in SHOW → o_SEG is stable for 20+ cycles and dwell resumes on release. i_next pulse with i_hold=1 → GAP on the next cycle.
- i_alert_req with hex 8'hAB mid-GAP → o_SEG=16'h8883 and o_alert=1 for 5 cycles, then SHOW on the same o_ch with a full 8-cycle dwell.
- i_alert_req repeated at alert cycle 3 with 8'h0F → display updates and the alert lasts 5 more cycles. i_alert_req and i_next in the same cycle → alert shown, no channel advance.
- i_reset asserted during ALERT → o_SEG=16'hFFFF, o_alert=0, o_ch=0 asynchronously; ch0 is shown on the first clock after release.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the two-digit 7-segment display path.
// Segment bytes are active-low, ordered {g,f,e,d,c,b,a}; a digit pair is
// {dp1, tens, dp0, units}. Provides the decimal (num2seg) and hex
// (hex2seg_couple) converters plus the scheduler state encoding.
package display_pkg;

    localparam logic [6:0]  SEG_BLANK = 7'h7F;
    localparam logic [6:0]  SEG_DASH  = 7'b0111111;
    localparam logic [15:0] OFF_PAIR  = 16'hFFFF;
    localparam logic [15:0] DASH_PAIR = 16'hBFBF;

    typedef enum logic [1:0] {SHOW, GAP, ALERT} state_t;

    function automatic logic [6:0] hex2seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Alert pair: both decimal points off, low nibble on the units digit.
    function automatic logic [15:0] hex2seg_couple(input logic [7:0] h);
        return {1'b1, hex2seg(h[7:4]), 1'b1, hex2seg(h[3:0])};
    endfunction

    // Decimal pair with pass-through points; out-of-range shows dashes.
    function automatic logic [15:0] num2seg(input logic [7:0] v, input logic [1:0] dp);
        logic [3:0] tens;
        logic [3:0] units;
        if (v > 8'd99)
            return DASH_PAIR;
        tens  = 4'(v / 8'd10);
        units = 4'(v % 8'd10);
        return {dp[1], hex2seg(tens), dp[0], hex2seg(units)};
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seg_next_ch.sv
// Round-robin next-channel finder.
//   cur    : currently selected channel index
//   en     : channel enable mask
//   nxt    : first enabled channel after cur (wrapping); cur if none other
//   any_en : at least one channel is enabled
module seg_next_ch #(
    parameter int N_CH = 4,
    localparam int CW = $clog2(N_CH)
) (
    input  logic [CW-1:0]   cur,
    input  logic [N_CH-1:0] en,
    output logic [CW-1:0]   nxt,
    output logic            any_en
);

    logic found;
    int   idx;

    // Offsets 1..N_CH; the last offset revisits cur so a lone enabled
    // channel selects itself.
    always_comb begin
        nxt    = cur;
        any_en = |en;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(cur) + k) % N_CH;
            if (!found && en[CW'(idx)]) begin
                nxt   = CW'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_display_scheduler.sv
// Time-multiplexes N_CH two-digit decimal channels onto one 7-segment pair,
// with optional blank gaps, hold, manual stepping and a timed hex alert.
//   i_clock, i_reset : clock, asynchronous active-high reset
//   i_value, i_dp    : per-channel value (8 bits) and decimal points (2 bits)
//   i_en             : channel enable mask
//   i_hold, i_next   : freeze dwell timer / advance to next channel
//   i_alert_req/hex  : start or retrigger alert with two hex digits
//   o_SEG            : {dp1,g..a, dp0,g..a}, active-low
//   o_ch, o_alert    : selected channel, alert active
module seg_display_scheduler
    import display_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int GAP_CYCLES   = 5_000_000,
    parameter int ALERT_CYCLES = 100_000_000,
    localparam int CW = $clog2(N_CH)
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [8*N_CH-1:0] i_value,
    input  logic [2*N_CH-1:0] i_dp,
    input  logic [N_CH-1:0]   i_en,
    input  logic              i_hold,
    input  logic              i_next,
    input  logic              i_alert_req,
    input  logic [7:0]        i_alert_hex,
    output logic [15:0]       o_SEG,
    output logic [CW-1:0]     o_ch,
    output logic              o_alert
);

    localparam int TW = $clog2(max3(DWELL_CYCLES, GAP_CYCLES, ALERT_CYCLES) + 1);
    localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] ALERT_LAST = TW'(ALERT_CYCLES - 1);

    state_t        state, state_d;
    logic [CW-1:0] ch, ch_d;
    logic [TW-1:0] timer, timer_d;
    logic [7:0]    alert_hex;
    logic [15:0]   seg_d;
    logic [CW-1:0] nxt;
    logic          any_en;
    logic [7:0]    cur_val;
    logic [1:0]    cur_dp;

    seg_next_ch #(.N_CH(N_CH)) u_next (
        .cur    (ch),
        .en     (i_en),
        .nxt    (nxt),
        .any_en (any_en)
    );

    always_comb begin
        cur_val = '0;
        cur_dp  = '1;
        for (int k = 0; k < N_CH; k++) begin
            if (ch == CW'(k)) begin
                cur_val = i_value[8*k +: 8];
                cur_dp  = i_dp[2*k +: 2];
            end
        end
    end

    // An alert request overrides everything, dropping any pending advance.
    // A disabled current channel is treated like an i_next pulse.
    always_comb begin
        state_d = state;
        ch_d    = ch;
        timer_d = timer;
        if (i_alert_req) begin
            state_d = ALERT;
            timer_d = '0;
        end else begin
            case (state)
                SHOW: begin
                    if (!any_en) begin
                        timer_d = '0;
                    end else if (i_next || !i_en[ch] || (!i_hold && timer == DWELL_LAST)) begin
                        timer_d = '0;
                        if (GAP_CYCLES == 0)
                            ch_d = nxt;
                        else
                            state_d = GAP;
                    end else if (!i_hold) begin
                        timer_d = timer + TW'(1);
                    end
                end
                GAP: begin
                    if (timer == GAP_LAST) begin
                        state_d = SHOW;
                        timer_d = '0;
                        ch_d    = nxt;
                    end else begin
                        timer_d = timer + TW'(1);
                    end
                end
                ALERT: begin
                    if (timer == ALERT_LAST) begin
                        state_d = SHOW;
                        timer_d = '0;
                    end else begin
                        timer_d = timer + TW'(1);
                    end
                end
                default: begin
                    state_d = SHOW;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Display follows the current state one cycle behind, so each state
    // cycle maps to exactly one displayed cycle.
    always_comb begin
        seg_d = OFF_PAIR;
        case (state)
            SHOW:    seg_d = any_en ? num2seg(cur_val, cur_dp) : DASH_PAIR;
            GAP:     seg_d = OFF_PAIR;
            ALERT:   seg_d = hex2seg_couple(alert_hex);
            default: seg_d = OFF_PAIR;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state     <= SHOW;
            ch        <= '0;
            timer     <= '0;
            alert_hex <= '0;
            o_SEG     <= OFF_PAIR;
            o_alert   <= 1'b0;
        end else begin
            state   <= state_d;
            ch      <= ch_d;
            timer   <= timer_d;
            if (i_alert_req)
                alert_hex <= i_alert_hex;
            o_SEG   <= seg_d;
            o_alert <= (state == ALERT);
        end
    end

    assign o_ch = ch;

endmodule

// File: tb/tb_seg_display_scheduler.sv
module tb_seg_display_scheduler;

    logic        i_clock;
    logic        i_reset;
    logic [31:0] i_value;
    logic [7:0]  i_dp;
    logic [3:0]  i_en;
    logic        i_hold;
    logic        i_next;
    logic        i_alert_req;
    logic [7:0]  i_alert_hex;
    logic [15:0] o_SEG;
    logic [1:0]  o_ch;
    logic        o_alert;

    int total  = 0;
    int passed = 0;

    seg_display_scheduler #(
        .N_CH(4), .DWELL_CYCLES(8), .GAP_CYCLES(2), .ALERT_CYCLES(5)
    ) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_value(i_value), .i_dp(i_dp),
        .i_en(i_en), .i_hold(i_hold), .i_next(i_next),
        .i_alert_req(i_alert_req), .i_alert_hex(i_alert_hex),
        .o_SEG(o_SEG), .o_ch(o_ch), .o_alert(o_alert)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge i_clock);
    endtask

    // Channel pairs: ch0=42 dp11 -> 99A4, ch1=19 dp10 -> F910,
    // ch2=55 dp01 -> 1292, ch3=7 dp11 -> C0F8. Ek = k-th posedge after release.
    initial begin
        i_reset = 1'b1;
        i_value = {8'd7, 8'd55, 8'd19, 8'd42};
        i_dp = {2'b11, 2'b01, 2'b10, 2'b11};
        i_en = 4'b1111;
        i_hold = 1'b0;
        i_next = 1'b0;
        i_alert_req = 1'b0;
        i_alert_hex = 8'h00;
        cyc(2);
        chk("rst_seg", o_SEG, 16'hFFFF);
        chk("rst_ch", {14'd0, o_ch}, 16'd0);
        chk("rst_alert", {15'd0, o_alert}, 16'd0);
        i_reset = 1'b0;

        cyc(1);
        chk("ch0_first", o_SEG, 16'h99A4);
        chk("ch0_idx", {14'd0, o_ch}, 16'd0);
        for (int i = 2; i <= 8; i++) begin
            cyc(1);
            chk("ch0_dwell", o_SEG, 16'h99A4);
        end
        cyc(1); chk("gap1", o_SEG, 16'hFFFF);
        cyc(1); chk("gap2", o_SEG, 16'hFFFF);
        chk("ch1_idx", {14'd0, o_ch}, 16'd1);
        cyc(1); chk("ch1_seg", o_SEG, 16'hF910);
        cyc(10); chk("ch2_seg", o_SEG, 16'h1292);
        chk("ch2_idx", {14'd0, o_ch}, 16'd2);
        cyc(10); chk("ch3_seg", o_SEG, 16'hC0F8);
        chk("ch3_idx", {14'd0, o_ch}, 16'd3);
        cyc(9); chk("wrap_idx", {14'd0, o_ch}, 16'd0);
        chk("wrap_gap", o_SEG, 16'hFFFF);
        cyc(1); chk("wrap_seg", o_SEG, 16'h99A4);

        // E41: only channels 0 and 2 enabled
        i_en = 4'b0101;
        cyc(9); chk("en0101_a", {14'd0, o_ch}, 16'd2);
        cyc(10); chk("en0101_b", {14'd0, o_ch}, 16'd0);
        cyc(10); chk("en0101_c", {14'd0, o_ch}, 16'd2);

        // E70: all disabled
        i_en = 4'b0000;
        cyc(1); chk("alloff_seg", o_SEG, 16'hBFBF);
        chk("alloff_ch", {14'd0, o_ch}, 16'd2);
        cyc(10); chk("alloff_seg2", o_SEG, 16'hBFBF);
        chk("alloff_ch2", {14'd0, o_ch}, 16'd2);

        // E81: re-enable, then out-of-range value on ch2
        i_en = 4'b1111;
        cyc(1); chk("reen_seg", o_SEG, 16'h1292);
        i_value[23:16] = 8'd123;
        cyc(1); chk("over99", o_SEG, 16'hBFBF);
        i_value[23:16] = 8'd55;

        // E83: hold for 20 cycles at timer=2
        i_hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            chk("hold_seg", o_SEG, 16'h1292);
        end
        chk("hold_ch", {14'd0, o_ch}, 16'd2);
        i_hold = 1'b0;
        cyc(6); chk("resume_last", o_SEG, 16'h1292);
        cyc(1); chk("resume_gap", o_SEG, 16'hFFFF);
        cyc(1); chk("ch3_after_hold", {14'd0, o_ch}, 16'd3);
        cyc(1); chk("ch3_seg2", o_SEG, 16'hC0F8);

        // E112: i_next while held
        i_hold = 1'b1;
        i_next = 1'b1;
        cyc(1); chk("next_prev", o_SEG, 16'hC0F8);
        i_next = 1'b0;
        i_hold = 1'b0;
        cyc(1); chk("next_gap", o_SEG, 16'hFFFF);
        chk("next_gap_ch", {14'd0, o_ch}, 16'd3);

        // E114: alert during last gap cycle
        i_alert_req = 1'b1;
        i_alert_hex = 8'hAB;
        cyc(1); chk("alert_lat", o_SEG, 16'hFFFF);
        i_alert_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("alert_seg", o_SEG, 16'h8883);
            chk("alert_flag", {15'd0, o_alert}, 16'd1);
        end
        cyc(1); chk("alert_ret", o_SEG, 16'hC0F8);
        chk("alert_ret_flag", {15'd0, o_alert}, 16'd0);
        chk("alert_ret_ch", {14'd0, o_ch}, 16'd3);
        cyc(7); chk("full_dwell", o_SEG, 16'hC0F8);
        cyc(1); chk("full_dwell_end", o_SEG, 16'hFFFF);
        cyc(2); chk("ch0_again", o_SEG, 16'h99A4);

        // E131: alert, retriggered at its third cycle
        i_alert_req = 1'b1;
        i_alert_hex = 8'hAB;
        cyc(1);
        i_alert_req = 1'b0;
        cyc(2); chk("retrig_pre", o_SEG, 16'h8883);
        i_alert_req = 1'b1;
        i_alert_hex = 8'h0F;
        cyc(1); chk("retrig_edge", o_SEG, 16'h8883);
        i_alert_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("retrig_seg", o_SEG, 16'hC08E);
            chk("retrig_flag", {15'd0, o_alert}, 16'd1);
        end
        cyc(1); chk("retrig_end", o_SEG, 16'h99A4);
        chk("retrig_end_flag", {15'd0, o_alert}, 16'd0);

        // E141: alert and next together
        i_alert_req = 1'b1;
        i_alert_hex = 8'h5A;
        i_next = 1'b1;
        cyc(1);
        i_alert_req = 1'b0;
        i_next = 1'b0;
        cyc(1); chk("both_seg", o_SEG, 16'h9288);
        chk("both_ch", {14'd0, o_ch}, 16'd0);
        cyc(4); chk("both_last", o_SEG, 16'h9288);
        cyc(1); chk("both_ret", o_SEG, 16'h99A4);
        chk("both_ret_ch", {14'd0, o_ch}, 16'd0);

        // E148: step to ch1, then alert, then reset mid-alert
        i_next = 1'b1;
        cyc(1);
        i_next = 1'b0;
        cyc(2); chk("step_ch1", {14'd0, o_ch}, 16'd1);
        i_alert_req = 1'b1;
        i_alert_hex = 8'hAB;
        cyc(1);
        i_alert_req = 1'b0;
        cyc(1); chk("pre_rst_seg", o_SEG, 16'h8883);
        chk("pre_rst_ch", {14'd0, o_ch}, 16'd1);
        i_reset = 1'b1;
        #1;
        chk("async_seg", o_SEG, 16'hFFFF);
        chk("async_alert", {15'd0, o_alert}, 16'd0);
        chk("async_ch", {14'd0, o_ch}, 16'd0);
        cyc(1); chk("rst_hold_seg", o_SEG, 16'hFFFF);
        i_reset = 1'b0;
        cyc(1); chk("post_rst_seg", o_SEG, 16'h99A4);
        chk("post_rst_ch", {14'd0, o_ch}, 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
